clock_display: RTL and testbench

CLOCK_DISPLAY -- requirements
Module: clock_display

---
 rtl/clock_display.sv | 113 +++++++++++
 tb/tb_clock_display.sv | 134 +++++++++++++
 2 files changed

// File: rtl/clock_display.sv
// Multiplexed six-digit HH:MM:SS seven-segment scanner with coherent per-scan snapshots.
// Optional CLOCK_DISPLAY_BLANK_EN blanks a leading zero in the hours-tens digit.
module clock_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_count_sec,
    input  logic [31:0] io_count_min,
    input  logic [31:0] io_count_hrs,
    output logic [6:0]  io_seg,
    output logic        io_dp,
    output logic [5:0]  io_an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [6:0]    r_snap_sec;
    logic [6:0]    r_snap_min;
    logic [6:0]    r_snap_hrs;

    logic          w_tick;
    logic          w_wrap;
    logic [6:0]    w_snap;
    logic [6:0]    w_digit;

    function automatic logic [6:0] clamp99(input logic [31:0] v);
        return (v > 32'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [6:0] seg_encode(input logic [6:0] d);
        logic [6:0] s;
        case (d)
            7'd0:    s = 7'h3F;
            7'd1:    s = 7'h06;
            7'd2:    s = 7'h5B;
            7'd3:    s = 7'h4F;
            7'd4:    s = 7'h66;
            7'd5:    s = 7'h6D;
            7'd6:    s = 7'h7D;
            7'd7:    s = 7'h07;
            7'd8:    s = 7'h7F;
            7'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == 3'd5);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Snapshots load on the same edge the index returns to 0, so digit 0 shows fresh data at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snap_sec <= 7'd0;
            r_snap_min <= 7'd0;
            r_snap_hrs <= 7'd0;
        end else if (w_wrap) begin
            r_snap_sec <= clamp99(io_count_sec);
            r_snap_min <= clamp99(io_count_min);
            r_snap_hrs <= clamp99(io_count_hrs);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_snap = 7'd0;
        case (r_idx)
            3'd0, 3'd1: w_snap = r_snap_sec;
            3'd2, 3'd3: w_snap = r_snap_min;
            3'd4, 3'd5: w_snap = r_snap_hrs;
            default:    w_snap = 7'd0;
        endcase
    end

    // Odd slots show tens, even slots show ones.
    assign w_digit = r_idx[0] ? (w_snap / 7'd10) : (w_snap % 7'd10);

    always_comb begin
        io_an  = 6'b000001 << r_idx;
        io_dp  = (r_idx == 3'd2) || (r_idx == 3'd4);
        io_seg = seg_encode(w_digit);
`ifdef CLOCK_DISPLAY_BLANK_EN
        if ((r_idx == 3'd5) && (w_digit == 7'd0)) begin
            io_seg = 7'h00;
        end
`else
        io_seg = seg_encode(w_digit);
`endif
    end

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with SCAN_DIV=4 (one digit slot per 4 clocks).
// Honours CLOCK_DISPLAY_BLANK_EN for the hours-tens leading-zero expectation.
module tb_clock_display;

    logic        clock;
    logic        reset;
    logic [31:0] io_count_sec;
    logic [31:0] io_count_min;
    logic [31:0] io_count_hrs;
    logic [6:0]  io_seg;
    logic        io_dp;
    logic [5:0]  io_an;

    int checks = 0;
    int errors = 0;

    clock_display #(.SCAN_DIV(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_count_sec (io_count_sec),
        .io_count_min (io_count_min),
        .io_count_hrs (io_count_hrs),
        .io_seg       (io_seg),
        .io_dp        (io_dp),
        .io_an        (io_an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [5:0] an, input logic [6:0] seg,
                              input logic dp);
        check({tag, ".an"},  {26'd0, io_an},  {26'd0, an});
        check({tag, ".seg"}, {25'd0, io_seg}, {25'd0, seg});
        check({tag, ".dp"},  {31'd0, io_dp},  {31'd0, dp});
    endtask

    localparam logic [6:0] HRS7_TENS =
`ifdef CLOCK_DISPLAY_BLANK_EN
        7'h00;
`else
        7'h3F;
`endif

    initial begin
        reset        = 1'b1;
        io_count_sec = 32'd37;
        io_count_min = 32'd5;
        io_count_hrs = 32'd14;
        #12;
        check_slot("reset_idle", 6'b000001, 7'h3F, 1'b0);

        @(negedge clock);
        reset = 1'b0;
        step(3);
        check("post_rel_3", {26'd0, io_an}, 32'h01);
        step(1);
        check_slot("post_rel_4", 6'b000010, 7'h3F, 1'b0);

        // Edge 24 after release: wrap and first snapshot load.
        step(20);
        check_slot("scan1_d0", 6'b000001, 7'h07, 1'b0);
        step(4);
        check_slot("scan1_d1", 6'b000010, 7'h4F, 1'b0);
        step(4);
        check_slot("scan1_d2", 6'b000100, 7'h6D, 1'b1);
        step(4);
        check_slot("scan1_d3", 6'b001000, 7'h3F, 1'b0);

        io_count_sec = 32'd12;
        step(4);
        check_slot("scan1_d4", 6'b010000, 7'h66, 1'b1);
        step(4);
        check_slot("scan1_d5", 6'b100000, 7'h06, 1'b0);

        io_count_hrs = 32'd150;
        step(4);
        check_slot("scan2_d0", 6'b000001, 7'h5B, 1'b0);
        step(4);
        check_slot("scan2_d1", 6'b000010, 7'h06, 1'b0);
        step(12);
        check_slot("clamp150_d4", 6'b010000, 7'h6F, 1'b1);
        step(4);
        check_slot("clamp150_d5", 6'b100000, 7'h6F, 1'b0);

        io_count_hrs = 32'd99;
        step(20);
        check_slot("hrs99_d4", 6'b010000, 7'h6F, 1'b1);
        step(4);
        check_slot("hrs99_d5", 6'b100000, 7'h6F, 1'b0);

        io_count_hrs = 32'd7;
        step(20);
        check_slot("hrs7_d4", 6'b010000, 7'h07, 1'b1);
        step(4);
        check_slot("hrs7_d5", 6'b100000, HRS7_TENS, 1'b0);

        // Mid-scan asynchronous reset between edges at slot 4.
        step(20);
        check_slot("pre_rst_d4", 6'b010000, 7'h07, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_slot("async_rst", 6'b000001, 7'h3F, 1'b0);
        #1;
        reset = 1'b0;
        step(4);
        check_slot("rst_snap_d1", 6'b000010, 7'h3F, 1'b0);
        step(4);
        check_slot("rst_snap_d2", 6'b000100, 7'h3F, 1'b1);
        step(12);
        check_slot("rst_snap_d5", 6'b100000, HRS7_TENS, 1'b0);
        step(4);
        check_slot("rst_reload_d0", 6'b000001, 7'h5B, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
